// File: rtl/seq_mux_if.sv
// seq_mux_if: channel-side and consumer-side signals of seq_mux.
// The mux itself connects through the slave modport. Its source/consumer
// environment connects through the master modport.
interface seq_mux_if #(
  parameter int SELECT_LINES = 4,
  parameter int DATA_WIDTH   = 1
);
  localparam int N = 1 << SELECT_LINES;

  logic                      mode;
  logic [SELECT_LINES-1:0]   select;
  logic [SELECT_LINES-1:0]   scan_limit;
  logic [DATA_WIDTH*N-1:0]   data_in;
  logic [N-1:0]              in_valid;
  logic [N-1:0]              in_ready;
  logic [DATA_WIDTH-1:0]     data_out;
  logic [SELECT_LINES-1:0]   out_chan;
  logic                      out_valid;
  logic                      out_ready;
  logic                      scan_wrap;

  modport master (
    output mode, select, scan_limit, data_in, in_valid, out_ready,
    input  in_ready, data_out, out_chan, out_valid, scan_wrap
  );

  modport slave (
    input  mode, select, scan_limit, data_in, in_valid, out_ready,
    output in_ready, data_out, out_chan, out_valid, scan_wrap
  );
endinterface

// File: rtl/seq_mux.sv
// seq_mux: registered, valid/ready channel mux with two select modes.
// In direct mode the external select chooses the channel. In scan mode an
// internal counter steps through channels 0..scan_limit.
// Optional feature macro SEQ_MUX_SKIP_EN: when it is defined, scan mode
// skips channels that are not valid, at one channel per cycle.
module seq_mux #(
  parameter     ARCHITECTURE = "BEHAVIORAL",
  parameter int SELECT_LINES = 4,
  parameter int DATA_WIDTH   = 1
) (
  input  logic clk,
  input  logic rst_n,
  seq_mux_if.slave bus
);
  localparam int N = 1 << SELECT_LINES;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  // Reserved vendor architectures share the behavioural datapath below.
  if (ARCHITECTURE == "VIRTEX5" || ARCHITECTURE == "VIRTEX6") begin : g_reserved_arch
  end

  logic [0:0]              state;
  logic [DATA_WIDTH-1:0]   data_r;
  logic [SELECT_LINES-1:0] chan_r;
  logic [SELECT_LINES-1:0] scan_cnt;
  logic                    wrap_r;

  logic [DATA_WIDTH-1:0]   chan_data [N];
  logic [SELECT_LINES-1:0] cur;
  logic                    load_en;
  logic                    capture;
  logic                    scan_step;
  logic [N-1:0]            rdy;

  // Split the flat input bus into one word per channel.
  for (genvar k = 0; k < N; k++) begin : g_chan
    assign chan_data[k] = bus.data_in[DATA_WIDTH*k +: DATA_WIDTH];
  end

  assign cur     = bus.mode ? scan_cnt : bus.select;
  assign load_en = (state == EMPTY) || bus.out_ready;
  assign capture = bus.in_valid[cur] && load_en;

`ifdef SEQ_MUX_SKIP_EN
  // Either take the current channel or skip past it when it is idle.
  assign scan_step = bus.mode && load_en;
`else
  // Strict order: the counter only moves after the current channel is taken.
  assign scan_step = bus.mode && capture;
`endif

  // Ready goes to the selected channel only, while the output slot can load.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    rdy = '0;
    if (load_en && rst_n) rdy[cur] = 1'b1;
  end

  // Output register, output state and scan counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state    <= EMPTY;
      data_r   <= '0;
      chan_r   <= '0;
      scan_cnt <= '0;
      wrap_r   <= 1'b0;
    end else begin
      wrap_r <= 1'b0;

      if (capture) begin
        data_r <= chan_data[cur];
        chan_r <= cur;
        state  <= FULL;
      end else if (state == FULL && bus.out_ready) begin
        state <= EMPTY;
      end

      if (!bus.mode) begin
        scan_cnt <= '0;
      end else if (scan_step) begin
        if (scan_cnt >= bus.scan_limit) begin
          scan_cnt <= '0;
          wrap_r   <= 1'b1;
        end else begin
          scan_cnt <= scan_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.data_out  = data_r;
  assign bus.out_chan  = chan_r;
  assign bus.out_valid = (state == FULL);
  assign bus.scan_wrap = wrap_r;
endmodule
